// File: rtl/tx_packet_framer.sv
// Frames a latched correlator packet into a byte stream (ASCII hex or raw binary)
// with a trailing CRC-8 and, in ASCII mode, a CR terminator.
module tx_packet_framer #(
   parameter int PACKET_SIZE = 256,
   parameter bit BINARY      = 1'b0
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [PACKET_SIZE-1:0] packet,
   input  logic                   load,
   input  logic                   enable,
   output logic [7:0]             byte_out,
   output logic                   byte_valid,
   input  logic                   byte_ready,
   output logic                   busy,
   output logic                   overrun
);

   localparam int NCHAR = BINARY ? PACKET_SIZE / 8 : PACKET_SIZE / 4;
   localparam int CW    = $clog2(PACKET_SIZE / 4 + 1);
   localparam logic [CW-1:0] LAST = CW'(NCHAR - 1);

   typedef enum logic [1:0] {IDLE, DATA, CRC, EOL} state_t;

   state_t                 state;
   logic [PACKET_SIZE-1:0] shreg;
   logic [7:0]             crc;
   logic [CW-1:0]          cnt;

   logic [PACKET_SIZE-1:0] shreg_next;
   logic [7:0]             top_byte;
   logic [7:0]             crc_fold;
   logic [7:0]             first_byte;
   logic                   xfer;
   logic                   accept;
   logic                   last_char;

   function automatic logic [7:0] hex_char(input logic [3:0] nib);
      return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   endfunction

   function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
      logic [7:0] r;
      r = c ^ d;
      for (int i = 0; i < 8; i++) begin
         r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
      end
      return r;
   endfunction

   // Handshake: a byte moves when byte_valid & byte_ready at a rising edge; byte_out
   // and byte_valid hold until then, and only reset or enable=0 may withdraw a byte.
   always_comb begin
      shreg_next = shreg << 8;
      top_byte   = shreg[PACKET_SIZE-1 -: 8];
      crc_fold   = crc8(crc, top_byte);
      xfer       = byte_valid & byte_ready;
      accept     = load & enable & (state == IDLE);
      last_char  = (cnt == LAST);
      first_byte = BINARY ? packet[PACKET_SIZE-1 -: 8] : hex_char(packet[PACKET_SIZE-1 -: 4]);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         shreg      <= '0;
         crc        <= '0;
         cnt        <= '0;
         byte_out   <= '0;
         byte_valid <= 1'b0;
         busy       <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= load & ~accept;
         if (!enable) begin
            state      <= IDLE;
            crc        <= '0;
            cnt        <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            busy       <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (load) begin
                     shreg      <= packet;
                     crc        <= '0;
                     cnt        <= '0;
                     state      <= DATA;
                     busy       <= 1'b1;
                     byte_valid <= 1'b1;
                     byte_out   <= first_byte;
                  end
               end
               DATA: begin
                  if (xfer) begin
                     cnt <= cnt + 1'b1;
                     // the raw top byte is complete after its low nibble goes out in ASCII mode
                     if (BINARY || cnt[0]) begin
                        crc   <= crc_fold;
                        shreg <= shreg_next;
                     end
                     if (last_char) begin
                        state    <= CRC;
                        cnt      <= '0;
                        byte_out <= BINARY ? crc_fold : hex_char(crc_fold[7:4]);
                     end else if (BINARY) begin
                        byte_out <= shreg_next[PACKET_SIZE-1 -: 8];
                     end else if (cnt[0]) begin
                        byte_out <= hex_char(shreg_next[PACKET_SIZE-1 -: 4]);
                     end else begin
                        byte_out <= hex_char(top_byte[3:0]);
                     end
                  end
               end
               CRC: begin
                  if (xfer) begin
                     if (BINARY) begin
                        state      <= IDLE;
                        byte_out   <= '0;
                        byte_valid <= 1'b0;
                        busy       <= 1'b0;
                     end else if (cnt == '0) begin
                        cnt      <= CW'(1);
                        byte_out <= hex_char(crc[3:0]);
                     end else begin
                        state    <= EOL;
                        cnt      <= '0;
                        byte_out <= 8'h0D;
                     end
                  end
               end
               EOL: begin
                  if (xfer) begin
                     state      <= IDLE;
                     byte_out   <= '0;
                     byte_valid <= 1'b0;
                     busy       <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tx_packet_framer.sv
// Bench for tx_packet_framer: one ASCII and one binary instance (16-bit packets),
// directed framing/backpressure/overrun/reset/enable cases plus randomized frames.
module tb_tx_packet_framer;

   localparam int PS = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic [PS-1:0] packet [2];
   logic          load [2];
   logic          enable [2];
   logic          byte_ready [2] = '{1'b0, 1'b0};
   logic [7:0]    byte_out [2];
   logic          byte_valid [2];
   logic          busy [2];
   logic          overrun [2];

   tx_packet_framer #(.PACKET_SIZE(PS), .BINARY(1'b0)) dut_asc (
      .clk(clk), .reset_n(reset_n), .packet(packet[0]), .load(load[0]),
      .enable(enable[0]), .byte_out(byte_out[0]), .byte_valid(byte_valid[0]),
      .byte_ready(byte_ready[0]), .busy(busy[0]), .overrun(overrun[0]));

   tx_packet_framer #(.PACKET_SIZE(PS), .BINARY(1'b1)) dut_bin (
      .clk(clk), .reset_n(reset_n), .packet(packet[1]), .load(load[1]),
      .enable(enable[1]), .byte_out(byte_out[1]), .byte_valid(byte_valid[1]),
      .byte_ready(byte_ready[1]), .busy(busy[1]), .overrun(overrun[1]));

   // ---------------- counters and checker ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
      end
   endtask

   // ---------------- reference model / scoreboard ----------------
   logic [7:0] exp_q0[$];
   logic [7:0] exp_q1[$];

   function automatic void q_push(input int m, input logic [7:0] b);
      if (m == 0) exp_q0.push_back(b);
      else exp_q1.push_back(b);
   endfunction

   function automatic int q_size(input int m);
      return (m == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   function automatic logic [7:0] q_pop(input int m);
      if (m == 0) return exp_q0.pop_front();
      return exp_q1.pop_front();
   endfunction

   function automatic void q_clear(input int m);
      if (m == 0) exp_q0.delete();
      else exp_q1.delete();
   endfunction

   function automatic logic [7:0] hex_ref(input int v);
      return (v < 10) ? 8'(48 + v) : 8'(55 + v);
   endfunction

   // CRC as the remainder of the whole message bit stream divided by x^8+x^2+x+1
   function automatic logic [7:0] crc_ref(input logic [PS-1:0] p);
      logic [7:0] r;
      logic       fb;
      r = 8'h00;
      for (int i = PS - 1; i >= 0; i--) begin
         fb = r[7] ^ p[i];
         r  = {r[6:0], 1'b0};
         if (fb) r = r ^ 8'h07;
      end
      return r;
   endfunction

   task automatic push_frame(input int m, input logic [PS-1:0] p);
      logic [7:0]    c;
      logic [PS-1:0] t;
      c = crc_ref(p);
      if (m == 0) begin
         for (int k = 0; k < PS / 4; k++) begin
            t = p >> (PS - 4 - 4 * k);
            q_push(0, hex_ref(int'(t[3:0])));
         end
         q_push(0, hex_ref(int'(c[7:4])));
         q_push(0, hex_ref(int'(c[3:0])));
         q_push(0, 8'h0D);
      end else begin
         for (int k = 0; k < PS / 8; k++) begin
            t = p >> (PS - 8 - 8 * k);
            q_push(1, t[7:0]);
         end
         q_push(1, c);
      end
   endtask

   task automatic push_bytes(input int m, input logic [63:0] v, input int n);
      for (int i = 0; i < n; i++) q_push(m, v[8 * (n - 1 - i) +: 8]);
   endtask

   // ---------------- monitor ----------------
   logic       hold_v [2] = '{1'b0, 1'b0};
   logic [7:0] hold_b [2] = '{8'h00, 8'h00};
   logic       ovr_prev [2] = '{1'b0, 1'b0};
   int         ovr_hi [2] = '{0, 0};
   int         ovr_rise [2] = '{0, 0};

   always @(negedge clk) begin
      for (int m = 0; m < 2; m++) begin
         if (reset_n) begin
            if (hold_v[m]) begin
               check("hold_valid", 32'(byte_valid[m]), 32'd1);
               check("hold_byte", 32'(byte_out[m]), 32'(hold_b[m]));
            end
            if (byte_valid[m] && byte_ready[m]) begin
               if (q_size(m) == 0) check("extra_byte", 32'(byte_out[m]), 32'h100);
               else check(m == 0 ? "asc_byte" : "bin_byte", 32'(byte_out[m]), 32'(q_pop(m)));
            end
            hold_v[m] <= byte_valid[m] && !byte_ready[m] && enable[m];
            hold_b[m] <= byte_out[m];
            if (overrun[m]) ovr_hi[m] <= ovr_hi[m] + 1;
            if (overrun[m] && !ovr_prev[m]) ovr_rise[m] <= ovr_rise[m] + 1;
            ovr_prev[m] <= overrun[m];
         end else begin
            hold_v[m]   <= 1'b0;
            ovr_prev[m] <= 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   int ready_mode [2];   // 0 always ready, 1 random, 2 pattern 1,0,0, 3 never
   int ready_tick = 0;
   int exp_ovr [2];

   always @(posedge clk) begin
      #1;
      ready_tick++;
      for (int m = 0; m < 2; m++) begin
         case (ready_mode[m])
            0: byte_ready[m] = 1'b1;
            1: byte_ready[m] = 1'($urandom_range(0, 1));
            2: byte_ready[m] = (ready_tick % 3 == 0);
            default: byte_ready[m] = 1'b0;
         endcase
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int m, input int budget);
      int n;
      n = 0;
      while (q_size(m) != 0 && n < budget) begin
         step();
         n++;
      end
      check("drain_left", 32'(q_size(m)), 32'd0);
      check("drain_busy", 32'(busy[m]), 32'd0);
      check("drain_valid", 32'(byte_valid[m]), 32'd0);
   endtask

   task automatic send(input int m, input logic [PS-1:0] p);
      packet[m] = p;
      load[m]   = 1'b1;
      push_frame(m, p);
      step();
      load[m] = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [PS-1:0] p;
      int            m;
      for (int i = 0; i < 2; i++) begin
         packet[i] = '0; load[i] = 1'b0; enable[i] = 1'b1;
         ready_mode[i] = 0; exp_ovr[i] = 0;
      end
      repeat (3) step();
      for (int i = 0; i < 2; i++) begin
         check("rst_valid", 32'(byte_valid[i]), 32'd0);
         check("rst_busy", 32'(busy[i]), 32'd0);
         check("rst_byte", 32'(byte_out[i]), 32'd0);
         check("rst_ovr", 32'(overrun[i]), 32'd0);
      end
      reset_n = 1'b1;
      step();

      // ASCII 0x1234, ready always: seven back-to-back bytes one cycle after load
      packet[0] = 16'h1234; load[0] = 1'b1;
      push_bytes(0, 64'h0031_3233_3446_310D, 7);
      step(); load[0] = 1'b0;
      for (int i = 0; i < 7; i++) begin
         check("t1_valid", 32'(byte_valid[0]), 32'd1);
         check("t1_busy", 32'(busy[0]), 32'd1);
         step();
      end
      check("t1_valid_end", 32'(byte_valid[0]), 32'd0);
      check("t1_busy_end", 32'(busy[0]), 32'd0);
      check("t1_left", 32'(q_size(0)), 32'd0);

      // binary 0x1234
      packet[1] = 16'h1234; load[1] = 1'b1;
      push_bytes(1, 64'h12_34F1, 3);
      step(); load[1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("t2_valid", 32'(byte_valid[1]), 32'd1);
         step();
      end
      check("t2_valid_end", 32'(byte_valid[1]), 32'd0);
      check("t2_left", 32'(q_size(1)), 32'd0);

      // backpressure
      ready_mode[0] = 2;
      step();
      packet[0] = 16'h1234; load[0] = 1'b1;
      push_bytes(0, 64'h0031_3233_3446_310D, 7);
      step(); load[0] = 1'b0;
      drain(0, 100);
      ready_mode[0] = 0;
      step(); step();

      // overrun on the 3rd data byte and on the final-transfer cycle
      send(0, 16'hABCD);                                   // now P1+1
      step();                                              // P2+1
      step(); packet[0] = '0; load[0] = 1'b1; exp_ovr[0]++; // P3+1
      step(); load[0] = 1'b0;                              // P4+1
      check("t4_ovr_pulse", 32'(overrun[0]), 32'd1);
      step();
      check("t4_ovr_clear", 32'(overrun[0]), 32'd0);
      step();
      step(); packet[0] = '0; load[0] = 1'b1; exp_ovr[0]++; // P7+1
      step();                                              // P8+1
      check("t4_ovr_final", 32'(overrun[0]), 32'd1);
      check("t4_busy_done", 32'(busy[0]), 32'd0);
      send(0, 16'($urandom));
      check("t4_reload_busy", 32'(busy[0]), 32'd1);
      check("t4_reload_ovr", 32'(overrun[0]), 32'd0);
      drain(0, 100);

      // asynchronous reset after two bytes of a frame
      step();
      packet[0] = 16'h1234; load[0] = 1'b1;
      push_bytes(0, 64'h0031_3233_3446_310D, 7);
      step(); load[0] = 1'b0;
      step(); load[0] = 1'b1;
      step(); load[0] = 1'b0;
      check("t5_ovr_pre", 32'(overrun[0]), 32'd1);
      check("t5_valid_pre", 32'(byte_valid[0]), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("t5_rst_valid", 32'(byte_valid[0]), 32'd0);
      check("t5_rst_busy", 32'(busy[0]), 32'd0);
      check("t5_rst_byte", 32'(byte_out[0]), 32'd0);
      check("t5_rst_ovr", 32'(overrun[0]), 32'd0);
      q_clear(0);
      repeat (2) step();
      reset_n = 1'b1;
      step();
      packet[0] = 16'h00FF; load[0] = 1'b1;
      push_bytes(0, 64'h0030_3046_4646_330D, 7);
      step(); load[0] = 1'b0;
      drain(0, 100);

      // enable drop mid-frame, with a load attempted while disabled
      step();
      packet[0] = 16'h1234; load[0] = 1'b1;
      push_bytes(0, 64'h0031_3233_3446_310D, 7);
      step(); load[0] = 1'b0;
      step();
      step(); enable[0] = 1'b0; load[0] = 1'b1; packet[0] = 16'hFFFF; exp_ovr[0]++;
      step(); enable[0] = 1'b1; load[0] = 1'b0;
      check("t6_valid", 32'(byte_valid[0]), 32'd0);
      check("t6_busy", 32'(busy[0]), 32'd0);
      check("t6_ovr", 32'(overrun[0]), 32'd1);
      q_clear(0);
      step();
      packet[0] = 16'h1234; load[0] = 1'b1;
      push_bytes(0, 64'h0031_3233_3446_310D, 7);
      step(); load[0] = 1'b0;
      drain(0, 100);

      // randomized frames with random backpressure and stray loads while busy
      ready_mode[0] = 1; ready_mode[1] = 1;
      step();
      for (int f = 0; f < 40; f++) begin
         m = int'($urandom_range(0, 1));
         p = 16'($urandom);
         send(m, p);
         repeat ($urandom_range(0, 3)) step();
         if ($urandom_range(0, 1) == 1 && q_size(m) > 0) begin
            packet[m] = 16'($urandom); load[m] = 1'b1; exp_ovr[m]++;
            step(); load[m] = 1'b0;
         end
         drain(m, 300);
      end
      step(); step();

      for (int i = 0; i < 2; i++) begin
         check("ovr_pulses", 32'(ovr_rise[i]), 32'(exp_ovr[i]));
         check("ovr_cycles", 32'(ovr_hi[i]), 32'(exp_ovr[i]));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #400000;
      n_err++;
      $display("FAIL watchdog: observed timeout expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "watchdog");
   end

endmodule
